instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Consumes the address pair from the program counter (addr, addr+1) and fetches both words from imem.
//  Single-outstanding-pair FSM issues two in-order requests and buffers {addr,instr} in a FIFO.
//  Presents instructions to decode one per cycle over a valid/ready handshake.
//  flush discards the queued entries and any in-flight responses.
// PARAMETERS
//  ADDR_W   32  address width
//  INSTR_W  32  instruction width
//  DEPTH    4   queue entries; power of 2, >=2
// PORTS
//  clk            in   1        single clock, all state updates on posedge
//  rst_n          in   1        reset, synchronous, active-low
//  pc_addr        in   ADDR_W   first fetch address from program counter
//  pc_addr_plus1  in   ADDR_W   second fetch address (addr+1)
//  pc_valid       in   1        address pair valid
//  pc_ready       out  1        pair accepted when pc_valid&&pc_ready
//  imem_req       out  1        memory request
//  imem_addr      out  ADDR_W   request address
//  imem_gnt       in   1        request accepted this cycle
//  imem_rvalid    in   1        read data valid; responses in request order, >=1 cycle after gnt
//  imem_rdata     in   INSTR_W  read data
//  flush          in   1        redirect: drop all fetched/in-flight work
//  dec_valid      out  1        queue head valid
//  dec_instr      out  INSTR_W  head instruction
//  dec_addr       out  ADDR_W   head address
//  dec_ready      in   1        decode pops head when dec_valid&&dec_ready
//  stall_cnt      out  32       present only with IFQ_PERF_CNT_EN
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM=IDLE, queue empty, outstanding=0, all outputs 0, stall_cnt=0.
//  FSM states: IDLE, REQ0, REQ1, WAIT, DRAIN.
//   IDLE: pc_ready=(count<=DEPTH-2). On accept latch addr0/addr1 -> REQ0.
//   REQ0: imem_req=1, imem_addr=addr0; on gnt -> REQ1.
//   REQ1: imem_req=1, imem_addr=addr1; on gnt -> WAIT.
//   WAIT: each rvalid pushes {addrK,rdata}, K=0 then 1; after second push -> IDLE.
//   DRAIN: rvalid discarded, outstanding decremented; outstanding==0 -> IDLE.
//  pc_ready is 0 in every state except IDLE; two slots are reserved at accept, so a push never meets a full queue.
//  Responses arriving in REQ1 (first response) are pushed normally.
//  Latency: accept at cycle N -> imem_req at N+1. With gnt both cycles and rvalid one cycle after each gnt,
//   first dec_valid at N+3.
//  Queue: simultaneous push and pop keeps count; pop on empty is ignored; dec_* are driven from head registers.
//  outstanding: +1 on gnt, -1 on rvalid, range 0..2.
//  flush (priority over all else):
//   - queue emptied next cycle; dec_valid=0 the cycle after flush.
//   - rvalid in the flush cycle is discarded.
//   - a gnt in the flush cycle counts as outstanding.
//   - next state is DRAIN if outstanding after this cycle >0, else IDLE.
//   - imem_req drops in the following cycle; it may be withdrawn without gnt only on flush.
//   - pc_valid in the flush cycle is not accepted.
//  rst_n low mid-operation: returns to the reset state; in-flight responses are ignored until a new accept.
// CONFIGURATION
//  IFQ_PERF_CNT_EN defined: stall_cnt counts cycles with pc_valid&&!pc_ready.
//   - Saturates at 32'hFFFF_FFFF; cleared by reset only, not by flush.
//  IFQ_PERF_CNT_EN undefined: stall_cnt port and counter are absent.
// STRUCTURE
//  ifq_pkg:
//   - fetch-state enum {IDLE,REQ0,REQ1,WAIT,DRAIN}
//   - entry struct {addr,instr}
//   - default ADDR_W/INSTR_W constants
//  Sub-module ifq_fifo: synchronous FIFO with DEPTH entries.
//   - ports: push, pop, clr (flush), count, head.
//   - full/empty from a pointer with one extra bit.
//  Top holds the FSM, address latches, outstanding counter and perf counter.
// TESTING
//  1. Reset, then pc_addr=0x10/0x11 with pc_valid.
//     gnt every cycle, rvalid 1 cycle later, data 0xA0/0xA1.
//     -> dec {0x10,0xA0} then {0x11,0xA1}; first dec_valid 3 cycles after accept.
//  2. dec_ready=0, three address pairs offered (DEPTH=4).
//     -> third pair held with pc_ready=0 once count=4; no push lost; release -> 4 entries drained in order.
//  3. Gnt withheld 5 cycles in REQ0.
//     -> imem_req/imem_addr=addr0 held stable; no REQ1 until gnt.
//  4. flush in WAIT with one response outstanding.
//     -> DRAIN; next rvalid (0xDEAD) not pushed; IDLE after; dec_valid=0.
//  5. flush in the same cycle as gnt of addr1 and as a pop.
//     -> outstanding=2, both responses dropped, queue empty.
//  6. With IFQ_PERF_CNT_EN: pc_valid held 7 cycles with pc_ready=0.
//     -> stall_cnt=7; unchanged by flush; 0 after rst_n=0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
//   fetch_state_e : fetch FSM states
//   ifq_entry_t   : queue entry {addr, instr} at the default widths
//   IFQ_ADDR_W / IFQ_INSTR_W / IFQ_DEPTH : default parameter values
package ifq_pkg;

    localparam int unsigned IFQ_ADDR_W  = 32;
    localparam int unsigned IFQ_INSTR_W = 32;
    localparam int unsigned IFQ_DEPTH   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StReq1,
        StWait,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic [IFQ_ADDR_W-1:0]  addr;
        logic [IFQ_INSTR_W-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO backing the fetch queue.
//   clk, rst_n : clock and synchronous active-low reset
//   push/wdata : write an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   clr        : empty the queue next cycle; wins over push/pop
//   count      : current occupancy, 0..DEPTH
//   head       : oldest entry, straight from the storage registers
module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wptr_q, rptr_q;
    logic             full, empty, do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = wptr_q - rptr_q;
    assign head    = mem_q[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[PTR_W-1:0]] <= wdata;
                wptr_q                   <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: accepts an address pair from the program counter,
// issues two in-order imem reads (one pair outstanding at most) and queues
// {addr, instr} for decode, one entry per cycle over valid/ready.
// Optional feature macro: IFQ_PERF_CNT_EN adds the stall_cnt output.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   pc_addr, pc_addr_plus1      fetch address pair
//   pc_valid / pc_ready         pair handshake
//   imem_req, imem_addr         memory request
//   imem_gnt                    request accepted
//   imem_rvalid, imem_rdata     in-order read responses
//   flush                       discard queued and in-flight work
//   dec_valid, dec_instr,       queue head towards decode
//   dec_addr / dec_ready
//   stall_cnt                   cycles with pc_valid && !pc_ready (macro only)
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned ADDR_W  = IFQ_ADDR_W,
    parameter int unsigned INSTR_W = IFQ_INSTR_W,
    parameter int unsigned DEPTH   = IFQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic [ADDR_W-1:0]  pc_addr_plus1,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_addr,
    input  logic               dec_ready
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int unsigned      CNT_W       = $clog2(DEPTH) + 1;
    // Two free slots are reserved at accept so a response push never sees a full queue.
    localparam logic [CNT_W-1:0] RESERVE_MAX = CNT_W'(DEPTH - 2);

    fetch_state_e               state_q, state_d;
    logic [ADDR_W-1:0]          addr0_q, addr0_d, addr1_q, addr1_d;
    logic                       rcv_q, rcv_d;      // first response of the pair already pushed
    logic [1:0]                 outst_q, outst_d;
    logic                       gnt_fire, rsp_fire, accept, push, pop;
    logic [ADDR_W-1:0]          push_addr;
    logic [CNT_W-1:0]           count;
    logic [ADDR_W+INSTR_W-1:0]  head;

    assign gnt_fire = imem_req & imem_gnt;
    // Responses with nothing outstanding (e.g. stale ones after reset) are ignored.
    assign rsp_fire = imem_rvalid & (outst_q != 2'd0);
    assign pc_ready = rst_n & (state_q == StIdle) & ~flush & (count <= RESERVE_MAX);
    assign accept   = pc_valid & pc_ready;
    assign dec_valid = (count != '0);
    assign pop      = dec_valid & dec_ready;
    assign push_addr = rcv_q ? addr1_q : addr0_q;
    assign {dec_addr, dec_instr} = head;

    always_comb begin
        outst_d = outst_q;
        case ({gnt_fire, rsp_fire})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr0_d   = addr0_q;
        addr1_d   = addr1_q;
        rcv_d     = rcv_q;
        imem_req  = 1'b0;
        imem_addr = '0;
        push      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr0_d = pc_addr;
                    addr1_d = pc_addr_plus1;
                    rcv_d   = 1'b0;
                    state_d = StReq0;
                end
            end
            StReq0: begin
                imem_req  = 1'b1;
                imem_addr = addr0_q;
                if (imem_gnt) begin
                    state_d = StReq1;
                end
            end
            StReq1: begin
                imem_req  = 1'b1;
                imem_addr = addr1_q;
                if (rsp_fire) begin
                    push  = 1'b1;
                    rcv_d = 1'b1;
                end
                if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rsp_fire) begin
                    push = 1'b1;
                    if (rcv_q) begin
                        rcv_d   = 1'b0;
                        state_d = StIdle;
                    end else begin
                        rcv_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (outst_d == 2'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            push    = 1'b0;
            rcv_d   = 1'b0;
            state_d = (outst_d != 2'd0) ? StDrain : StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr0_q <= '0;
            addr1_q <= '0;
            rcv_q   <= 1'b0;
            outst_q <= 2'd0;
        end else begin
            state_q <= state_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            rcv_q   <= rcv_d;
            outst_q <= outst_d;
        end
    end

    ifq_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clr   (flush),
        .wdata ({push_addr, imem_rdata}),
        .count (count),
        .head  (head)
    );

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (pc_valid && !pc_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed vector table, a few
// hand-written corner sequences and a randomized run against a queue-based
// reference model with an in-order memory responder.
module tb_instr_fetch_queue;
    import ifq_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr, pc_addr_plus1;
    logic        pc_valid, pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        dec_valid;
    logic [31:0] dec_instr, dec_addr;
    logic        dec_ready;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch_queue #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .DEPTH   (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr       (pc_addr),
        .pc_addr_plus1 (pc_addr_plus1),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .flush         (flush),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_addr      (dec_addr),
        .dec_ready     (dec_ready)
`ifdef IFQ_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- reference model ----------------
    bit          m_busy;       // a pair has been accepted and is not yet complete
    logic [31:0] m_req[$];     // addresses still to be requested, in order
    logic [31:0] m_rsp[$];     // granted addresses awaiting their response
    int          m_drain;      // responses to throw away after a flush
    ifq_entry_t  m_q[$];       // expected queue contents, head first
    int          m_stall;
    // memory responder
    logic [31:0] r_addr[$];
    int          r_due[$];
    int          cyc;
    int          last_due;

    function automatic bit model_pr();
        return rst_n && !m_busy && (m_drain == 0) && (m_q.size() <= D - 2) && !flush;
    endfunction

    function automatic void model_clear();
        m_busy = 0; m_req.delete(); m_rsp.delete(); m_drain = 0; m_q.delete(); m_stall = 0;
        r_addr.delete(); r_due.delete(); last_due = cyc;
    endfunction

    // One model-checked cycle. Caller sets pc_valid/pc_addr/flush/dec_ready.
    task automatic step(input bit g, input int lat);
        bit e_pr, e_req, gf, rf;
        int due;
        imem_gnt      = g;
        pc_addr_plus1 = pc_addr + 32'd1;
        if (r_due.size() > 0 && r_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_of(r_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        e_pr  = model_pr();
        e_req = (m_req.size() > 0);
        chk("pc_ready", pc_ready, e_pr);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_req[0]);
        chk("dec_valid", dec_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("dec_addr", dec_addr, m_q[0].addr);
            chk("dec_instr", dec_instr, m_q[0].instr);
        end
`ifdef IFQ_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        gf = e_req && g;
        rf = imem_rvalid;
        if (pc_valid && !e_pr) m_stall++;
        if (flush) begin
            m_drain = m_drain + m_rsp.size() + int'(gf) - int'(rf);
            m_q.delete(); m_req.delete(); m_rsp.delete();
            m_busy = 0;
        end else begin
            if (dec_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (rf) begin
                if (m_drain > 0) m_drain--;
                else if (m_rsp.size() > 0) m_q.push_back('{addr: m_rsp.pop_front(), instr: imem_rdata});
            end
            if (gf) m_rsp.push_back(m_req.pop_front());
            if (m_busy && m_req.size() == 0 && m_rsp.size() == 0) m_busy = 0;
            if (pc_valid && e_pr) begin
                m_busy = 1;
                m_req.push_back(pc_addr);
                m_req.push_back(pc_addr + 32'd1);
            end
        end
        if (rf) begin
            void'(r_due.pop_front());
            void'(r_addr.pop_front());
        end
        if (gf) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            r_due.push_back(due);
            r_addr.push_back(imem_addr);
            last_due = due;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pc_valid = 0; pc_addr = 0; pc_addr_plus1 = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = 0; flush = 0; dec_ready = 0;
        @(posedge clk);
        #1;
        chk("rst pc_ready", pc_ready, 0);
        chk("rst imem_req", imem_req, 0);
        chk("rst imem_addr", imem_addr, 0);
        chk("rst dec_valid", dec_valid, 0);
        chk("rst dec_addr", dec_addr, 0);
        chk("rst dec_instr", dec_instr, 0);
`ifdef IFQ_PERF_CNT_EN
        chk("rst stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst release pc_ready", pc_ready, 1);
        model_clear();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pv;  logic [31:0] pa; logic gnt; logic rv; logic [31:0] rd;
        logic        fl;  logic dr;
        logic        e_pr; logic e_req; logic [31:0] e_ia;
        logic        e_dv; logic [31:0] e_da; logic [31:0] e_di;
    } vec_t;

    function automatic vec_t mk(logic pv, logic [31:0] pa, logic gnt, logic rv, logic [31:0] rd,
                                logic fl, logic dr, logic e_pr, logic e_req, logic [31:0] e_ia,
                                logic e_dv, logic [31:0] e_da, logic [31:0] e_di);
        vec_t v;
        v.pv = pv; v.pa = pa; v.gnt = gnt; v.rv = rv; v.rd = rd; v.fl = fl; v.dr = dr;
        v.e_pr = e_pr; v.e_req = e_req; v.e_ia = e_ia; v.e_dv = e_dv; v.e_da = e_da; v.e_di = e_di;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        pc_valid = v.pv; pc_addr = v.pa; pc_addr_plus1 = v.pa + 32'd1;
        imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rd;
        flush = v.fl; dec_ready = v.dr;
        #1;
        chk($sformatf("vec%0d pc_ready", idx), pc_ready, v.e_pr);
        chk($sformatf("vec%0d imem_req", idx), imem_req, v.e_req);
        if (v.e_req) chk($sformatf("vec%0d imem_addr", idx), imem_addr, v.e_ia);
        chk($sformatf("vec%0d dec_valid", idx), dec_valid, v.e_dv);
        if (v.e_dv) begin
            chk($sformatf("vec%0d dec_addr", idx), dec_addr, v.e_da);
            chk($sformatf("vec%0d dec_instr", idx), dec_instr, v.e_di);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        bit   acc;
        cyc = 0;
        do_reset();

        // basic pair: accept, two grants, responses one cycle after each grant
        tbl.push_back(mk(1, 'h10, 0, 0, 0,       0, 1,  1, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 0,       0, 1,  0, 1, 'h10,  0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 1, 'hA0,    0, 1,  0, 1, 'h11,  0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 1, 'hA1,    0, 1,  0, 0, 0,     1, 'h10, 'hA0));
        tbl.push_back(mk(0, 0,    0, 0, 0,       0, 1,  1, 0, 0,     1, 'h11, 'hA1));
        tbl.push_back(mk(0, 0,    0, 0, 0,       0, 1,  1, 0, 0,     0, 0, 0));
        // flush in WAIT with one response outstanding; that response is dropped
        tbl.push_back(mk(1, 'h20, 0, 0, 0,       0, 0,  1, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 0,       0, 0,  0, 1, 'h20,  0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 1, 'hB0,    0, 0,  0, 1, 'h21,  0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,       1, 0,  0, 0, 0,     1, 'h20, 'hB0));
        tbl.push_back(mk(0, 0,    0, 1, 'hDEAD,  0, 0,  0, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,       0, 0,  1, 0, 0,     0, 0, 0));
        // flush together with gnt of addr1 and a pop: two responses to drain
        tbl.push_back(mk(1, 'h40, 0, 0, 0,       0, 0,  1, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 0,       0, 0,  0, 1, 'h40,  0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 1, 'hC0,    0, 0,  0, 1, 'h41,  0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 1, 'hC1,    0, 0,  0, 0, 0,     1, 'h40, 'hC0));
        tbl.push_back(mk(1, 'h50, 0, 0, 0,       0, 0,  1, 0, 0,     1, 'h40, 'hC0));
        tbl.push_back(mk(0, 0,    1, 0, 0,       0, 0,  0, 1, 'h50,  1, 'h40, 'hC0));
        tbl.push_back(mk(0, 0,    1, 0, 0,       1, 1,  0, 1, 'h51,  1, 'h40, 'hC0));
        tbl.push_back(mk(0, 0,    0, 1, 'hD0,    0, 0,  0, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 1, 'hD1,    0, 0,  0, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,       0, 0,  1, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,       0, 0,  1, 0, 0,     0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

        // grant withheld in REQ0: request and address held stable
        do_reset();
        dec_ready = 1; pc_valid = 1; pc_addr = 'h200;
        step(0, 1);
        pc_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3 req held", imem_req, 1);
            chk("t3 addr0 held", imem_addr, 'h200);
            step(0, 1);
        end
        step(1, 1);
        chk("t3 addr1 after gnt", imem_addr, 'h201);
        for (int i = 0; i < 6; i++) step(1, 1);

        // back-pressure: queue fills, third pair held, drained in order
        dec_ready = 0; pc_valid = 1; pc_addr = 'h100;
        for (int i = 0; i < 12; i++) begin
            acc = pc_valid && model_pr();
            step(1, 1);
            if (acc) pc_addr = pc_addr + 32'd2;
        end
        chk("t2 third pair held", pc_ready, 0);
        chk("t2 third pair addr", pc_addr, 'h104);
        dec_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t2 drain valid", dec_valid, 1);
            chk("t2 drain addr", dec_addr, 'h100 + k);
            chk("t2 drain instr", dec_instr, mem_of('h100 + k));
            acc = pc_valid && model_pr();
            step(1, 1);
            if (acc) begin
                pc_addr  = pc_addr + 32'd2;
                pc_valid = 0;
            end
        end
        pc_valid = 0;
        for (int i = 0; i < 8; i++) step(1, 1);

`ifdef IFQ_PERF_CNT_EN
        // stall counter: seven stalled cycles, survives flush, cleared by reset
        do_reset();
        pc_addr = 'h300;
        for (int i = 0; i < 12; i++) begin
            pc_valid = model_pr();
            acc = pc_valid;
            step(1, 1);
            if (acc) pc_addr = pc_addr + 32'd2;
        end
        pc_valid = 1;
        for (int i = 0; i < 7; i++) step(1, 1);
        pc_valid = 0;
        step(1, 1);
        chk("t6 stall_cnt", stall_cnt, 7);
        flush = 1;
        step(1, 1);
        flush = 0;
        step(1, 1);
        chk("t6 stall after flush", stall_cnt, 7);
        do_reset();
        chk("t6 stall after reset", stall_cnt, 0);
`endif

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            pc_valid  = ($urandom_range(99) < 60);
            pc_addr   = $urandom;
            flush     = ($urandom_range(99) < 4);
            dec_ready = ($urandom_range(99) < 60);
            step($urandom_range(99) < 70, 1 + $urandom_range(2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
